sccb_slave: RTL
===============

// Module: sccb_slave
// PURPOSE
//  SCCB responder (camera-side model) for the 2-wire sio_c/sio_d bus. Decodes 3-phase
//  writes and 2-phase reads from the team's SCCB master into a local 8-bit register file.
//  Drives read data back on the shared sio_d line. Used as the sensor model in
//  system-level benches, and as a config-register target for FPGA-internal SCCB links.
// PARAMETERS
//  SLV_ID   8'h42  write ID; read ID = SLV_ID|1 (8'h43); other IDs ignored
//  REG_NUM  16     register file depth; legal addresses 0..REG_NUM-1
//  BAD_RD   8'hFF  data returned for reads at address >= REG_NUM
// PORTS
//  clk         in   1  system clock (25 MHz)
//  rst_n       in   1  asynchronous active-low reset
//  sio_c       in   1  SCCB clock from master (idle high)
//  sio_d_r     in   1  sio_d pad input (pulled up)
//  sio_d_w     out  1  sio_d value driven by this block
//  en_sio_d_w  out  1  1 = block drives sio_d; 0 = released
//  wr_vld      out  1  one-cycle pulse when a register is written
//  wr_addr     out  8  address of the last write; valid with wr_vld
//  wr_data     out  8  data of the last write; valid with wr_vld
//  host_addr   in   8  local read port address
//  host_rdata  out  8  combinational reg[host_addr]; BAD_RD if out of range
//  busy        out  1  1 from START until STOP/abort
// BEHAVIOUR
//  Reset: sio_d_w=1, en_sio_d_w=0, wr_vld=0, wr_addr=0, wr_data=0, busy=0.
//   All regs=0, sub_addr=0, state=IDLE.
//  Input path: sio_c and sio_d_r each use a 2-flop synchroniser, then a registered
//   copy for edge detection. Edges act 3 clk after the pin changes.
//  START = sio_d fall while sio_c high. STOP = sio_d rise while sio_c high.
//   Both are checked before the state logic, in every state.
//   START -> ID, bit_cnt=0, busy=1. A START mid-transfer is a repeated start:
//   abort, no commit.
//   STOP -> IDLE, busy=0, en_sio_d_w=0.
//  Bits are sampled on the sio_c rise. Every phase is 8 bits MSB-first plus one X bit.
//   The X bit is sampled and ignored.
//  FSM: IDLE, ID, ADDR, WDATA, RDATA, WAIT_STOP.
//   ID (9 bits): if byte==SLV_ID -> ADDR. If byte==SLV_ID|1 -> RDATA.
//    Any other byte -> WAIT_STOP.
//   ADDR (9 bits): sub_addr <= byte after bit 8 -> WDATA.
//   WDATA (9 bits): on the 8th sampled bit, if sub_addr<REG_NUM write reg[sub_addr].
//    wr_vld pulses 1 clk later with wr_addr/wr_data. If sub_addr>=REG_NUM, no write and
//    no pulse. Then -> WAIT_STOP.
//   A STOP after ADDR completes = 2-phase write: sub_addr is kept, nothing is written.
//   RDATA: load shreg = reg[sub_addr] (BAD_RD if out of range) when the X bit of ID is
//    sampled.
//    On each of the next 8 sio_c falls: en_sio_d_w=1, sio_d_w=shreg MSB, then shift.
//    On the sio_c fall after the 8th data rise: en_sio_d_w=0, sio_d_w=1 (master NA bit
//    floats high) -> WAIT_STOP.
//   WAIT_STOP: ignore clocks until STOP or START.
//  en_sio_d_w is never 1 outside RDATA. A write phase never drives sio_d (no ACK in SCCB).
//  sub_addr is not auto-incremented and persists across transactions.
//  A STOP/START mid-RDATA releases the bus in the same clk the condition is detected.
//  rst_n asserted mid-transfer: immediate return to the reset state, bus released.
// CONFIGURATION
//  SCCB_GLITCH_FILTER_EN defined: after the synchronisers, sio_c/sio_d pass a 3-sample
//   agreement filter. A level changes only after 3 equal consecutive samples.
//   This adds 2 clk latency and rejects pulses <=2 clk.
//  Not defined: synchroniser only. Pulses of 1 clk can create false edges.
// TESTING
//  1 3-phase write ID 42, addr 05, data A7, stop -> reg[5]=A7; one wr_vld with
//    wr_addr=05, wr_data=A7; en_sio_d_w=0 throughout.
//  2 2-phase write ID 42, addr 05, stop; then ID 43 -> slave drives 1010_0111 MSB-first
//    on sio_d; master sees rdata=A7; bus released before the NA bit; busy falls after STOP.
//  3 Write ID 44, addr 02, data 55 -> no wr_vld, reg[2] unchanged, en_sio_d_w=0.
//  4 Write addr 20 (>=REG_NUM), data 11 -> no wr_vld; a read of addr 20 returns FF.
//  5 Repeated START after 4 bits of WDATA; then write ID 42, addr 03, data 3C ->
//    only reg[3]=3C; the aborted write is not committed.
//  6 rst_n low during the RDATA 3rd bit -> en_sio_d_w=0 within 1 clk; all regs=0;
//    host_rdata(0)=00.
//  Plus (SCCB_GLITCH_FILTER_EN only): 1-clk pulse on sio_d while sio_c is high ->
//    no START/STOP detected.

Source files
------------

// File: rtl/sccb_slave.sv
// SCCB responder: decodes 3-phase writes / 2-phase reads into a local register file.
// Optional `define SCCB_GLITCH_FILTER_EN adds a 3-sample agreement filter on sio_c/sio_d.
`timescale 1ns/1ps
module sccb_slave #(
  parameter logic [7:0] SLV_ID  = 8'h42,
  parameter int         REG_NUM = 16,
  parameter logic [7:0] BAD_RD  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sio_c,
  input  logic       sio_d_r,
  output logic       sio_d_w,
  output logic       en_sio_d_w,
  output logic       wr_vld,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       busy
);

  localparam int         AW      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [8:0] REG_LIM = 9'(REG_NUM);
  localparam logic [7:0] RD_ID   = SLV_ID | 8'h01;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ID        = 3'd1,
    S_ADDR      = 3'd2,
    S_WDATA     = 3'd3,
    S_RDATA     = 3'd4,
    S_WAIT_STOP = 3'd5
  } state_t;

  state_t     state_r, state_nxt;
  logic [1:0] c_sync_r, d_sync_r;
  logic       c_lvl_s, d_lvl_s;
  logic       c_prev_r, d_prev_r;
  logic       c_rise_s, c_fall_s, start_s, stop_s;
  logic [3:0] bit_cnt_r;
  logic [7:0] rx_r, tx_r, sub_addr_r;
  logic [7:0] regs_r [REG_NUM];
  logic       busy_r, sio_d_w_r, en_r, wr_vld_r;
  logic [7:0] wr_addr_r, wr_data_r;
  logic [7:0] rx_byte_s, sub_rdata_s;
  logic       sub_in_range_s, host_in_range_s;
  logic       cnt_clr_s, cnt_inc_s, shift_s, load_tx_s, drive_s, release_s;
  logic       addr_ld_s, wr_s, busy_nxt_s, rx_bit_s, x_bit_s;

  // Two-flop synchronisers for both bus lines (idle high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync_r <= 2'b11;
      d_sync_r <= 2'b11;
    end else begin
      c_sync_r <= {c_sync_r[0], sio_c};
      d_sync_r <= {d_sync_r[0], sio_d_r};
    end
  end

`ifdef SCCB_GLITCH_FILTER_EN
  logic [1:0] c_hist_r, d_hist_r;
  logic       c_flt_r, d_flt_r;

  // Level moves only when the current and two previous samples agree
  always_comb begin
    c_lvl_s = c_flt_r;
    d_lvl_s = d_flt_r;
    if ((c_sync_r[1] == c_hist_r[0]) && (c_sync_r[1] == c_hist_r[1])) begin
      c_lvl_s = c_sync_r[1];
    end else begin
      c_lvl_s = c_flt_r;
    end
    if ((d_sync_r[1] == d_hist_r[0]) && (d_sync_r[1] == d_hist_r[1])) begin
      d_lvl_s = d_sync_r[1];
    end else begin
      d_lvl_s = d_flt_r;
    end
  end

  // Sample history and held filter level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_hist_r <= 2'b11;
      d_hist_r <= 2'b11;
      c_flt_r  <= 1'b1;
      d_flt_r  <= 1'b1;
    end else begin
      c_hist_r <= {c_hist_r[0], c_sync_r[1]};
      d_hist_r <= {d_hist_r[0], d_sync_r[1]};
      c_flt_r  <= c_lvl_s;
      d_flt_r  <= d_lvl_s;
    end
  end
`else
  assign c_lvl_s = c_sync_r[1];
  assign d_lvl_s = d_sync_r[1];
`endif

  // Delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_prev_r <= 1'b1;
      d_prev_r <= 1'b1;
    end else begin
      c_prev_r <= c_lvl_s;
      d_prev_r <= d_lvl_s;
    end
  end

  assign c_rise_s = c_lvl_s & ~c_prev_r;
  assign c_fall_s = ~c_lvl_s & c_prev_r;
  assign start_s  = c_lvl_s & c_prev_r & d_prev_r & ~d_lvl_s;
  assign stop_s   = c_lvl_s & c_prev_r & ~d_prev_r & d_lvl_s;
  assign rx_bit_s = c_rise_s && (bit_cnt_r != 4'd8);
  assign x_bit_s  = c_rise_s && (bit_cnt_r == 4'd8);
  assign rx_byte_s = {rx_r[6:0], d_lvl_s};

  assign sub_in_range_s  = ({1'b0, sub_addr_r} < REG_LIM);
  assign host_in_range_s = ({1'b0, host_addr} < REG_LIM);
  assign sub_rdata_s     = sub_in_range_s ? regs_r[sub_addr_r[AW-1:0]] : BAD_RD;
  assign host_rdata      = host_in_range_s ? regs_r[host_addr[AW-1:0]] : BAD_RD;

  // Next-state and datapath strobes; START/STOP override every state
  always_comb begin
    state_nxt  = state_r;
    cnt_clr_s  = 1'b0;
    cnt_inc_s  = 1'b0;
    shift_s    = 1'b0;
    load_tx_s  = 1'b0;
    drive_s    = 1'b0;
    release_s  = 1'b0;
    addr_ld_s  = 1'b0;
    wr_s       = 1'b0;
    busy_nxt_s = busy_r;
    if (start_s) begin
      state_nxt  = S_ID;
      cnt_clr_s  = 1'b1;
      release_s  = 1'b1;
      busy_nxt_s = 1'b1;
    end else if (stop_s) begin
      state_nxt  = S_IDLE;
      cnt_clr_s  = 1'b1;
      release_s  = 1'b1;
      busy_nxt_s = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_nxt = S_IDLE;
        end
        S_ID: begin
          shift_s   = rx_bit_s;
          cnt_inc_s = rx_bit_s;
          if (x_bit_s) begin
            cnt_clr_s = 1'b1;
            if (rx_r == SLV_ID) begin
              state_nxt = S_ADDR;
            end else if (rx_r == RD_ID) begin
              state_nxt = S_RDATA;
              load_tx_s = 1'b1;
            end else begin
              state_nxt = S_WAIT_STOP;
            end
          end else begin
            state_nxt = S_ID;
          end
        end
        S_ADDR: begin
          shift_s   = rx_bit_s;
          cnt_inc_s = rx_bit_s;
          if (x_bit_s) begin
            cnt_clr_s = 1'b1;
            addr_ld_s = 1'b1;
            state_nxt = S_WDATA;
          end else begin
            state_nxt = S_ADDR;
          end
        end
        S_WDATA: begin
          shift_s   = rx_bit_s;
          cnt_inc_s = rx_bit_s;
          wr_s      = rx_bit_s && (bit_cnt_r == 4'd7) && sub_in_range_s;
          if (x_bit_s) begin
            cnt_clr_s = 1'b1;
            state_nxt = S_WAIT_STOP;
          end else begin
            state_nxt = S_WDATA;
          end
        end
        S_RDATA: begin
          // Data changes on falls; the fall after the 8th rise frees the NA bit
          if (c_fall_s) begin
            if (bit_cnt_r == 4'd8) begin
              release_s = 1'b1;
              state_nxt = S_WAIT_STOP;
            end else begin
              drive_s = 1'b1;
            end
          end else begin
            cnt_inc_s = rx_bit_s;
          end
        end
        S_WAIT_STOP: begin
          state_nxt = S_WAIT_STOP;
        end
        default: begin
          state_nxt = S_IDLE;
          release_s = 1'b1;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Shift registers, register file and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= 4'd0;
      rx_r       <= 8'h00;
      tx_r       <= 8'h00;
      sub_addr_r <= 8'h00;
      busy_r     <= 1'b0;
      sio_d_w_r  <= 1'b1;
      en_r       <= 1'b0;
      wr_vld_r   <= 1'b0;
      wr_addr_r  <= 8'h00;
      wr_data_r  <= 8'h00;
      for (int i = 0; i < REG_NUM; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      busy_r   <= busy_nxt_s;
      wr_vld_r <= wr_s;
      if (cnt_clr_s) begin
        bit_cnt_r <= 4'd0;
      end else if (cnt_inc_s) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end
      if (shift_s) begin
        rx_r <= rx_byte_s;
      end
      if (load_tx_s) begin
        tx_r <= sub_rdata_s;
      end else if (drive_s) begin
        tx_r <= {tx_r[6:0], 1'b0};
      end
      if (addr_ld_s) begin
        sub_addr_r <= rx_r;
      end
      if (wr_s) begin
        regs_r[sub_addr_r[AW-1:0]] <= rx_byte_s;
        wr_addr_r <= sub_addr_r;
        wr_data_r <= rx_byte_s;
      end
      if (release_s) begin
        en_r      <= 1'b0;
        sio_d_w_r <= 1'b1;
      end else if (drive_s) begin
        en_r      <= 1'b1;
        sio_d_w_r <= tx_r[7];
      end
    end
  end

  assign sio_d_w    = sio_d_w_r;
  assign en_sio_d_w = en_r;
  assign wr_vld     = wr_vld_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;

endmodule
